splash_screen_pal: RTL and testbench

//  Avalon-ST video (VIP protocol) test/splash source, successor to the fixed 4-bpp generator. Emits a

---
 rtl/splash_screen_pal.sv | 226 ++++++++++++++++++++++
 tb/tb_splash_screen_pal.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/splash_screen_pal.sv
// splash_screen_pal
// Avalon-ST video (VIP protocol) splash source. Each frame is a control packet
// (frame width/height, progressive), a video header beat and FRAME_WIDTH x
// FRAME_HEIGHT pixels. Pixels inside the picture window come from a paletted
// picture stored in an external synchronous ROM. All other pixels take bg_color.
// Ports:
//   clk, reset_n               clock, asynchronous active-low reset
//   enable                     allows the next frame to start (sampled in IDLE)
//   bg_color                   background pixel {B,G,R}
//   pal_we/pal_addr/pal_wdata  palette write port
//   rom_addr/rom_rdata         picture ROM (read data one clock after address)
//   aso_*                      Avalon-ST source, ready latency 0
//   frame_done                 one-clock pulse when the video EOP is accepted
module splash_screen_pal #(
    parameter int PIXELS_IN_PARALLEL = 1,
    parameter int BPP                = 4,
    parameter int ROM_WIDTH          = 16,
    parameter int FRAME_WIDTH        = 800,
    parameter int FRAME_HEIGHT       = 480,
    parameter int PIC_WIDTH          = 400,
    parameter int PIC_HEIGHT         = 160,
    parameter int PIC_X              = 200,
    parameter int PIC_Y              = 160,
    parameter int EMPTY_WIDTH        = 4,
    localparam int ROM_WORDS         = PIC_WIDTH * PIC_HEIGHT * BPP / ROM_WIDTH,
    localparam int ROM_ADDR          = (ROM_WORDS > 1) ? $clog2(ROM_WORDS) : 1
) (
    input  logic                            clk,
    input  logic                            reset_n,
    input  logic                            enable,
    input  logic [23:0]                     bg_color,
    input  logic                            pal_we,
    input  logic [BPP-1:0]                  pal_addr,
    input  logic [23:0]                     pal_wdata,
    output logic [ROM_ADDR-1:0]             rom_addr,
    input  logic [ROM_WIDTH-1:0]            rom_rdata,
    output logic                            aso_startofpacket,
    output logic                            aso_endofpacket,
    output logic                            aso_valid,
    output logic [24*PIXELS_IN_PARALLEL-1:0] aso_data,
    input  logic                            aso_ready,
    output logic [EMPTY_WIDTH-1:0]          aso_empty,
    output logic                            frame_done
);

    localparam int PIP        = PIXELS_IN_PARALLEL;
    localparam int DW         = 24 * PIP;
    localparam int XBEATS     = FRAME_WIDTH / PIP;
    localparam int CTRL_BEATS = 4 / PIP;
    localparam int SUBS       = ROM_WIDTH / (BPP * PIP);
    localparam int SW         = (SUBS > 1) ? $clog2(SUBS) : 1;
    localparam int PAL_N      = 2 ** BPP;
    localparam int PAL_STEP   = 255 / (PAL_N - 1);

    localparam logic [15:0] FW16 = 16'(FRAME_WIDTH);
    localparam logic [15:0] FH16 = 16'(FRAME_HEIGHT);
    // Twelve control symbols, symbol 0 in the LSBs: 0xF, width nibbles MSN
    // first, height nibbles MSN first, interlace 0x3, then two unused zeros.
    localparam logic [95:0] CTRL_VEC = {
        8'h00, 8'h00, 8'h03,
        {4'h0, FH16[3:0]}, {4'h0, FH16[7:4]}, {4'h0, FH16[11:8]}, {4'h0, FH16[15:12]},
        {4'h0, FW16[3:0]}, {4'h0, FW16[7:4]}, {4'h0, FW16[11:8]}, {4'h0, FW16[15:12]},
        8'h0F
    };

    if (PIC_X + PIC_WIDTH > FRAME_WIDTH || PIC_Y + PIC_HEIGHT > FRAME_HEIGHT) begin : g_bad_window
        $error("splash_screen_pal: picture does not fit inside the frame");
    end
    if (PIC_X % PIP != 0 || ROM_WIDTH % (BPP * PIP) != 0 || (PIC_WIDTH * BPP) % ROM_WIDTH != 0) begin : g_bad_align
        $error("splash_screen_pal: picture/ROM alignment does not match the beat size");
    end

    typedef enum logic [1:0] {S_IDLE, S_CTRL, S_VHDR, S_VDATA} state_t;

    state_t              state_q, state_d;
    logic [1:0]          beat_q, beat_d;
    logic [15:0]         x_q, x_d, y_q, y_d;
    logic [SW-1:0]       sub_q, sub_d;
    logic [ROM_ADDR-1:0] rom_ptr_q, rom_ptr_d;
    logic                valid_q, sop_q, eop_q, vid_q, frame_done_q;
    logic [DW-1:0]       data_q;
    logic [23:0]         pal_q [PAL_N];

    logic                load, accept, in_pic;
    logic                gen, gen_sop, gen_eop, gen_vid;
    logic [DW-1:0]       gen_data, pix_data;

    // The output register may take a new beat when it is empty or being drained.
    assign load   = !valid_q || aso_ready;
    assign accept = valid_q && aso_ready;

    // The picture left edge is beat aligned, so pixel 0 decides for the whole beat.
    assign in_pic = (int'(x_q) * PIP >= PIC_X) && (int'(x_q) * PIP < PIC_X + PIC_WIDTH) &&
                    (int'(y_q) >= PIC_Y) && (int'(y_q) < PIC_Y + PIC_HEIGHT);

    // rom_rdata always holds the word at rom_ptr_q: the ROM is fed the next
    // pointer value so that the word is ready on the very next beat.
    assign rom_addr = rom_ptr_d;

    always_comb begin
        logic [BPP-1:0] idx;
        idx      = '0;
        pix_data = '0;
        for (int p = 0; p < PIP; p++) begin
            idx = rom_rdata[(int'(sub_q) * PIP + p) * BPP +: BPP];
            pix_data[p*24 +: 24] = in_pic ? pal_q[idx] : bg_color;
        end
    end

    always_comb begin
        state_d   = state_q;
        beat_d    = beat_q;
        x_d       = x_q;
        y_d       = y_q;
        sub_d     = sub_q;
        rom_ptr_d = rom_ptr_q;
        gen       = 1'b0;
        gen_sop   = 1'b0;
        gen_eop   = 1'b0;
        gen_vid   = 1'b0;
        gen_data  = '0;
        case (state_q)
            S_IDLE: begin
                beat_d = '0;
                if (enable) state_d = S_CTRL;
            end
            S_CTRL: begin
                if (load) begin
                    gen      = 1'b1;
                    gen_data = CTRL_VEC[int'(beat_q) * DW +: DW];
                    gen_sop  = (beat_q == 2'd0);
                    gen_eop  = (int'(beat_q) == CTRL_BEATS - 1);
                    if (gen_eop) state_d = S_VHDR;
                    else         beat_d  = beat_q + 2'd1;
                end
            end
            S_VHDR: begin
                if (load) begin
                    gen       = 1'b1;
                    gen_sop   = 1'b1;
                    state_d   = S_VDATA;
                    x_d       = '0;
                    y_d       = '0;
                    sub_d     = '0;
                    rom_ptr_d = '0;
                end
            end
            S_VDATA: begin
                if (load) begin
                    gen      = 1'b1;
                    gen_vid  = 1'b1;
                    gen_data = pix_data;
                    gen_eop  = (int'(x_q) == XBEATS - 1) && (int'(y_q) == FRAME_HEIGHT - 1);
                    // Step to the next ROM word only once its last index group is used.
                    if (in_pic) begin
                        if (int'(sub_q) == SUBS - 1) begin
                            sub_d     = '0;
                            rom_ptr_d = rom_ptr_q + ROM_ADDR'(1);
                        end else begin
                            sub_d = sub_q + SW'(1);
                        end
                    end
                    if (int'(x_q) == XBEATS - 1) begin
                        x_d = '0;
                        y_d = y_q + 16'd1;
                    end else begin
                        x_d = x_q + 16'd1;
                    end
                    if (gen_eop) state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= S_IDLE;
            beat_q       <= '0;
            x_q          <= '0;
            y_q          <= '0;
            sub_q        <= '0;
            rom_ptr_q    <= '0;
            valid_q      <= 1'b0;
            sop_q        <= 1'b0;
            eop_q        <= 1'b0;
            vid_q        <= 1'b0;
            data_q       <= '0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            beat_q       <= beat_d;
            x_q          <= x_d;
            y_q          <= y_d;
            sub_q        <= sub_d;
            rom_ptr_q    <= rom_ptr_d;
            frame_done_q <= accept && eop_q && vid_q;
            if (load) begin
                valid_q <= gen;
                if (gen) begin
                    sop_q  <= gen_sop;
                    eop_q  <= gen_eop;
                    vid_q  <= gen_vid;
                    data_q <= gen_data;
                end
            end
        end
    end

    // Palette comes out of reset as a grey ramp from black to white.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < PAL_N; i++) pal_q[i] <= {3{8'(i * PAL_STEP)}};
        end else if (pal_we) begin
            pal_q[pal_addr] <= pal_wdata;
        end
    end

    assign aso_valid         = valid_q;
    assign aso_startofpacket = sop_q;
    assign aso_endofpacket   = eop_q;
    assign aso_data          = data_q;
    assign aso_empty         = '0;
    assign frame_done        = frame_done_q;

endmodule

// File: tb/tb_splash_screen_pal.sv
module tb_splash_screen_pal;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;

    // DUT A: 1 pixel/beat, 4 bpp, 8x4 frame, 4x2 picture at (2,1)
    logic        enable_a = 1'b0, pal_we_a = 1'b0, ready_a = 1'b1;
    logic [23:0] bg_a = 24'h0A0B0C, pal_wdata_a = '0, data_a;
    logic [3:0]  pal_addr_a = '0, empty_a;
    logic [0:0]  rom_addr_a;
    logic [15:0] rom_rdata_a = '0;
    logic        sop_a, eop_a, valid_a, frame_done_a;
    logic [15:0] rom_a [2] = '{16'h7A51, 16'hF0C3};

    // DUT B: 4 pixels/beat, 8 bpp, 32-bit ROM, 8x4 frame, 4x2 picture at (4,1)
    logic        enable_b = 1'b0, pal_we_b = 1'b0, ready_b = 1'b1;
    logic [23:0] bg_b = 24'hA1B2C3, pal_wdata_b = '0;
    logic [7:0]  pal_addr_b = '0;
    logic [95:0] data_b;
    logic [3:0]  empty_b;
    logic [0:0]  rom_addr_b;
    logic [31:0] rom_rdata_b = '0;
    logic        sop_b, eop_b, valid_b, frame_done_b;
    logic [31:0] rom_b [2] = '{32'h800501FF, 32'h007F1002};

    int n_checks = 0, n_fail = 0;

    logic [23:0] pal_m [16];
    logic [23:0] cap_d [64], ref_d [64];
    logic        cap_s [64], cap_e [64], ref_s [64], ref_e [64];
    int          cnt, fd_cnt, hold_err;

    splash_screen_pal #(
        .PIXELS_IN_PARALLEL(1), .BPP(4), .ROM_WIDTH(16), .FRAME_WIDTH(8), .FRAME_HEIGHT(4),
        .PIC_WIDTH(4), .PIC_HEIGHT(2), .PIC_X(2), .PIC_Y(1), .EMPTY_WIDTH(4)
    ) dut_a (
        .clk(clk), .reset_n(reset_n), .enable(enable_a), .bg_color(bg_a),
        .pal_we(pal_we_a), .pal_addr(pal_addr_a), .pal_wdata(pal_wdata_a),
        .rom_addr(rom_addr_a), .rom_rdata(rom_rdata_a),
        .aso_startofpacket(sop_a), .aso_endofpacket(eop_a), .aso_valid(valid_a),
        .aso_data(data_a), .aso_ready(ready_a), .aso_empty(empty_a), .frame_done(frame_done_a)
    );

    splash_screen_pal #(
        .PIXELS_IN_PARALLEL(4), .BPP(8), .ROM_WIDTH(32), .FRAME_WIDTH(8), .FRAME_HEIGHT(4),
        .PIC_WIDTH(4), .PIC_HEIGHT(2), .PIC_X(4), .PIC_Y(1), .EMPTY_WIDTH(4)
    ) dut_b (
        .clk(clk), .reset_n(reset_n), .enable(enable_b), .bg_color(bg_b),
        .pal_we(pal_we_b), .pal_addr(pal_addr_b), .pal_wdata(pal_wdata_b),
        .rom_addr(rom_addr_b), .rom_rdata(rom_rdata_b),
        .aso_startofpacket(sop_b), .aso_endofpacket(eop_b), .aso_valid(valid_b),
        .aso_data(data_b), .aso_ready(ready_b), .aso_empty(empty_b), .frame_done(frame_done_b)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        rom_rdata_a <= rom_a[rom_addr_a];
        rom_rdata_b <= rom_b[rom_addr_b];
    end

    task automatic pal_reset_model();
        for (int i = 0; i < 16; i++) pal_m[i] = {3{8'(i * 17)}};
    endtask

    // Expected DUT A beat k of a frame as {sop, eop, data}.
    function automatic logic [25:0] exp_a(input int k);
        logic [23:0] d;
        logic [15:0] w;
        int n, x, y, p;
        case (k)
            0: d = 24'h00000F;
            1: d = 24'h000800;
            2: d = 24'h040000;
            3: d = 24'h000003;
            4: d = 24'h000000;
            default: begin
                n = k - 5; x = n % 8; y = n / 8;
                if (x >= 2 && x < 6 && y >= 1 && y < 3) begin
                    p = (y - 1) * 4 + (x - 2);
                    w = rom_a[p / 4];
                    d = pal_m[w[(p % 4) * 4 +: 4]];
                end else begin
                    d = bg_a;
                end
            end
        endcase
        return {(k == 0 || k == 4), (k == 3 || k == 36), d};
    endfunction

    // Sink for DUT A: captures one full frame (37 beats), drops enable after
    // drop_at beats, optionally writes palette entry 5 after wr_at beats.
    task automatic cap_a(input int ready_pct, input int drop_at, input int wr_at, input logic [23:0] wr_val);
        int cyc;
        logic pv, pr, ps, pe;
        logic [23:0] pd;
        cnt = 0; fd_cnt = 0; hold_err = 0; cyc = 0;
        pv = 1'b0; pr = 1'b1; ps = 1'b0; pe = 1'b0; pd = '0;
        while (cnt < 37 && cyc < 3000) begin
            @(negedge clk);
            cyc++;
            pal_we_a = 1'b0;
            if (frame_done_a) fd_cnt++;
            if (pv && !pr && (!valid_a || data_a !== pd || sop_a !== ps || eop_a !== pe)) hold_err++;
            ready_a = ($urandom_range(99) < ready_pct);
            if (valid_a && ready_a) begin
                cap_d[cnt] = data_a; cap_s[cnt] = sop_a; cap_e[cnt] = eop_a;
                cnt++;
                if (cnt == drop_at) enable_a = 1'b0;
                if (cnt == wr_at) begin
                    pal_we_a = 1'b1; pal_addr_a = 4'd5; pal_wdata_a = wr_val;
                end
            end
            pv = valid_a; pr = ready_a; pd = data_a; ps = sop_a; pe = eop_a;
        end
        pal_we_a = 1'b0;
        ready_a  = 1'b1;
        repeat (3) begin
            @(negedge clk);
            if (frame_done_a) fd_cnt++;
        end
    endtask

    task automatic test_reset();
        #2;
        n_checks++; if (valid_a !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", valid_a); end
        n_checks++; if (sop_a !== 1'b0 || eop_a !== 1'b0) begin n_fail++; $display("FAIL reset_sop_eop: got %b%b want 00", sop_a, eop_a); end
        n_checks++; if (data_a !== 24'h0) begin n_fail++; $display("FAIL reset_data: got %h want 000000", data_a); end
        n_checks++; if (frame_done_a !== 1'b0) begin n_fail++; $display("FAIL reset_frame_done: got %b want 0", frame_done_a); end
        n_checks++; if (rom_addr_a !== 1'b0) begin n_fail++; $display("FAIL reset_rom_addr: got %h want 0", rom_addr_a); end
        n_checks++; if (empty_a !== 4'h0) begin n_fail++; $display("FAIL reset_empty: got %h want 0", empty_a); end
        n_checks++; if (valid_b !== 1'b0) begin n_fail++; $display("FAIL reset_valid_b: got %b want 0", valid_b); end
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_frame();
        enable_a = 1'b1;
        cap_a(100, 1, -1, '0);
        n_checks++; if (cnt !== 37) begin n_fail++; $display("FAIL frame_beats: got %0d want 37", cnt); end
        for (int k = 0; k < 37; k++) begin
            n_checks++;
            if ({cap_s[k], cap_e[k], cap_d[k]} !== exp_a(k)) begin
                n_fail++; $display("FAIL frame_beat%0d: got %h want %h", k, {cap_s[k], cap_e[k], cap_d[k]}, exp_a(k));
            end
            ref_d[k] = cap_d[k]; ref_s[k] = cap_s[k]; ref_e[k] = cap_e[k];
        end
        n_checks++; if (cap_d[15] !== 24'h111111) begin n_fail++; $display("FAIL frame_pic_2_1: got %h want 111111", cap_d[15]); end
        n_checks++; if (cap_d[5] !== 24'h0A0B0C) begin n_fail++; $display("FAIL frame_bg_0_0: got %h want 0a0b0c", cap_d[5]); end
        n_checks++; if (fd_cnt !== 1) begin n_fail++; $display("FAIL frame_done_pulse: got %0d clks want 1", fd_cnt); end
    endtask

    task automatic test_backpressure();
        enable_a = 1'b1;
        cap_a(50, 1, -1, '0);
        n_checks++; if (cnt !== 37) begin n_fail++; $display("FAIL bp_beats: got %0d want 37", cnt); end
        for (int k = 0; k < 37; k++) begin
            n_checks++;
            if ({cap_s[k], cap_e[k], cap_d[k]} !== {ref_s[k], ref_e[k], ref_d[k]}) begin
                n_fail++; $display("FAIL bp_beat%0d: got %h want %h", k, {cap_s[k], cap_e[k], cap_d[k]}, {ref_s[k], ref_e[k], ref_d[k]});
            end
        end
        n_checks++; if (hold_err !== 0) begin n_fail++; $display("FAIL bp_hold: got %0d unstable cycles want 0", hold_err); end
        n_checks++; if (fd_cnt !== 1) begin n_fail++; $display("FAIL bp_frame_done: got %0d want 1", fd_cnt); end
    endtask

    task automatic test_pip4();
        logic [95:0] exp_d [10];
        logic [95:0] got_d [10];
        logic        got_s [10], got_e [10];
        logic [95:0] bg4;
        int c, cyc;
        bg4 = {4{24'hA1B2C3}};
        exp_d[0] = 96'h000003_040000_000800_00000F;
        exp_d[1] = '0;
        for (int k = 2; k < 10; k++) exp_d[k] = bg4;
        exp_d[5] = {24'h808080, 24'h050505, 24'h010101, 24'hFFFFFF};
        exp_d[7] = {24'h000000, 24'h7F7F7F, 24'h101010, 24'h020202};
        c = 0; cyc = 0;
        enable_b = 1'b1;
        while (c < 10 && cyc < 500) begin
            @(negedge clk);
            cyc++;
            if (valid_b && ready_b) begin
                got_d[c] = data_b; got_s[c] = sop_b; got_e[c] = eop_b;
                c++;
                enable_b = 1'b0;
            end
        end
        n_checks++; if (c !== 10) begin n_fail++; $display("FAIL pip4_beats: got %0d want 10", c); end
        for (int k = 0; k < c; k++) begin
            n_checks++;
            if (got_d[k] !== exp_d[k] || got_s[k] !== (k <= 1) || got_e[k] !== (k == 0 || k == 9)) begin
                n_fail++; $display("FAIL pip4_beat%0d: got %b%b %h want %b%b %h", k, got_s[k], got_e[k], got_d[k], (k <= 1), (k == 0 || k == 9), exp_d[k]);
            end
        end
        repeat (3) @(negedge clk);
    endtask

    task automatic test_palette_write();
        n_checks++; if (ref_d[16] !== 24'h555555) begin n_fail++; $display("FAIL pal_reset_value: got %h want 555555", ref_d[16]); end
        enable_a = 1'b1;
        cap_a(100, 1, 6, 24'h123456);
        pal_m[5] = 24'h123456;
        n_checks++; if (cap_d[16] !== 24'h123456) begin n_fail++; $display("FAIL pal_written: got %h want 123456", cap_d[16]); end
        for (int k = 0; k < 37; k++) begin
            n_checks++;
            if ({cap_s[k], cap_e[k], cap_d[k]} !== exp_a(k)) begin
                n_fail++; $display("FAIL pal_beat%0d: got %h want %h", k, {cap_s[k], cap_e[k], cap_d[k]}, exp_a(k));
            end
        end
    endtask

    task automatic test_enable();
        int vcount;
        vcount = 0;
        enable_a = 1'b0;
        repeat (20) begin
            @(negedge clk);
            if (valid_a) vcount++;
        end
        n_checks++; if (vcount !== 0) begin n_fail++; $display("FAIL en_idle_valid: got %0d valid clks want 0", vcount); end
        enable_a = 1'b1;
        cap_a(100, 12, -1, '0);
        n_checks++; if (cnt !== 37 || cap_e[36] !== 1'b1) begin n_fail++; $display("FAIL en_drop_complete: got %0d beats eop %b want 37 1", cnt, cap_e[36]); end
        n_checks++; if (fd_cnt !== 1) begin n_fail++; $display("FAIL en_drop_frame_done: got %0d want 1", fd_cnt); end
        vcount = 0;
        repeat (30) begin
            @(negedge clk);
            if (valid_a) vcount++;
        end
        n_checks++; if (vcount !== 0) begin n_fail++; $display("FAIL en_stays_idle: got %0d valid clks want 0", vcount); end
    endtask

    task automatic test_reset_mid_frame();
        int xfer, cyc;
        xfer = 0; cyc = 0;
        enable_a = 1'b1;
        ready_a  = 1'b1;
        while (xfer < 12 && cyc < 500) begin
            @(negedge clk);
            cyc++;
            if (valid_a && ready_a) xfer++;
        end
        n_checks++; if (xfer !== 12) begin n_fail++; $display("FAIL rst_mid_reach: got %0d beats want 12", xfer); end
        reset_n = 1'b0;
        #1;
        n_checks++; if (valid_a !== 1'b0) begin n_fail++; $display("FAIL rst_mid_valid: got %b want 0", valid_a); end
        n_checks++; if (rom_addr_a !== 1'b0 || frame_done_a !== 1'b0) begin n_fail++; $display("FAIL rst_mid_ctl: got addr %h fd %b want 0 0", rom_addr_a, frame_done_a); end
        pal_reset_model();
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        cap_a(100, 1, -1, '0);
        n_checks++; if (cap_s[0] !== 1'b1 || cap_d[0] !== 24'h00000F) begin n_fail++; $display("FAIL rst_restart_ctrl: got sop %b data %h want 1 00000f", cap_s[0], cap_d[0]); end
        n_checks++; if (cnt !== 37) begin n_fail++; $display("FAIL rst_restart_beats: got %0d want 37", cnt); end
        for (int k = 0; k < 37; k++) begin
            n_checks++;
            if ({cap_s[k], cap_e[k], cap_d[k]} !== exp_a(k)) begin
                n_fail++; $display("FAIL rst_beat%0d: got %h want %h", k, {cap_s[k], cap_e[k], cap_d[k]}, exp_a(k));
            end
        end
    endtask

    initial begin
        pal_reset_model();
        test_reset();
        test_frame();
        test_backpressure();
        test_pip4();
        test_palette_write();
        test_enable();
        test_reset_mid_frame();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
